jtag_user_dr_endpoint: RTL and testbench
========================================

# jtag_user_dr_endpoint

Device-side endpoint of the BSCANE2 USER4 data-register channel; the counterpart of the host bench that drives `scan_dr_hw_jtag` sequences. It deserializes 8-bit host frames shifted in on `tdi` into a byte stream for the puzzle logic. On a readback scan, it serializes a `RESULT_WIDTH` result word onto `tdo`, LSB first. It sits between the BSCANE2 primitive outputs and the puzzle solver inside `user_logic`.

## Interface
Parameters:
- `RESULT_WIDTH`, 32: width of the readback word and of the DR shift register; must be ≥ 8.

Ports:
- `tck`  in  1: BSCANE2 TCK; the only clock; all logic on rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `tdi`  in  1: serial data from host.
- `tdo`  out  1: serial data to host; equals `shreg[0]` combinationally.
- `test_logic_reset`  in  1: TAP in Test-Logic-Reset; synchronous soft clear.
- `run_test_idle`  in  1: TAP in Run-Test/Idle; informational, no effect.
- `ir_is_user`  in  1: IR holds USER4; gates capture, shift and update.
- `capture_dr`, `shift_dr`, `update_dr`  in  1 each: TAP DR state flags.
- `result`  in  RESULT_WIDTH: solver answer.
- `result_valid`  in  1: `result` is final.
- `inbound_byte`  out  8: last received byte.
- `inbound_valid`  out  1: one-cycle strobe qualifying `inbound_byte`.
- `frame_error`  out  1: sticky; a write-length scan had neither 8 nor ≥ `RESULT_WIDTH` bits.

## Operation
- State machine: IDLE → CAPTURED on `capture_dr`; CAPTURED/SHIFTING → SHIFTING on `shift_dr`. SHIFTING holds through Exit1/Pause/Exit2 while all flags are low. Any state → IDLE on `update_dr`, with the decision below.
- CAPTURE: `shreg <= result_valid ? result : 0`; `bitcnt <= 0`.
- SHIFT: `shreg <= {tdi, shreg[RESULT_WIDTH-1:1]}`; `bitcnt` increments and saturates at `RESULT_WIDTH`. `bitcnt` is `$clog2(RESULT_WIDTH)+1` bits wide.
- UPDATE decision on `bitcnt`:
  - == 8: `inbound_byte <= shreg[RESULT_WIDTH-1 -: 8]` (first-shifted bit is bit 0); pulse `inbound_valid`.
  - == `RESULT_WIDTH`: readback complete; no byte emitted.
  - == 0: no-op.
  - Any other value: set `frame_error`; no byte emitted.
- `update_dr` seen in IDLE (no prior capture) is a no-op.
- `ir_is_user` low: `capture_dr`/`shift_dr`/`update_dr` are ignored; state, `shreg` and `bitcnt` hold.
- `test_logic_reset` high: state → IDLE, `bitcnt` → 0, `inbound_valid` → 0. `shreg`, `inbound_byte` and `frame_error` hold.
- Simultaneous flags (illegal TAP encoding), priority: `test_logic_reset` > `capture_dr` > `shift_dr` > `update_dr`.

## Timing
- The host changes signals on falling `tck`; the block samples on rising `tck`.
- `tdo` is valid from the rising edge that executed capture/shift until the next rising edge. The host samples it on falling edges, so bit j of `result` is visible before the (j+1)-th shift edge.
- `inbound_valid` rises at the rising edge following the one where `update_dr` is sampled high, and lasts exactly one `tck` cycle. `inbound_byte` holds its value until the next accepted frame.
- Back-to-back frames (6+8 = 14 `tck` per host byte) produce at most one strobe per frame; there is no backpressure and no buffering.
- `result` is sampled only at capture; changes mid-scan do not affect the word being shifted.
- Reset values (`rst_n` low at a rising edge): state IDLE, `shreg` 0 (so `tdo` = 0), `bitcnt` 0, `inbound_byte` 0x00, `inbound_valid` 0, `frame_error` 0.
- A reset mid-shift aborts the frame; no strobe is emitted for it.

## Test plan
- Write frame: capture, 8 shifts of 0x41 LSB-first, exit1, update → `inbound_byte`=0x41 and `inbound_valid` high for exactly one cycle, one edge after update.
- Readback: `result`=0x0000_0A2B, `result_valid`=1, capture plus 32 shifts with `tdi`=0. The bits sampled on `tdo` at falling edges reassemble 0x0000_0A2B; no `inbound_valid`.
- Not ready: `result_valid`=0 → a 32-bit readback returns 0x0000_0000. Assert `result_valid`, rescan → the correct value is returned.
- Gating and malformed frames: a 5-bit scan sets `frame_error`=1 with no strobe. A frame with `ir_is_user`=0 leaves all outputs unchanged.
- Abort: assert `rst_n`=0 after 4 shifts → all outputs at reset values. The next complete 0x0A frame yields `inbound_byte`=0x0A.
- Stream: 100 back-to-back random bytes → exactly 100 strobes, in order, with matching values.

Source files
------------

// File: rtl/jtag_user_dr_endpoint.sv
// jtag_user_dr_endpoint
//
// Device-side endpoint of the BSCANE2 USER4 data-register channel. Host
// write scans of exactly 8 bits are turned into a byte stream with a
// one-cycle strobe. Readback scans shift out a RESULT_WIDTH result word
// on tdo, LSB first.
//
// Ports:
//   tck               - BSCANE2 TCK, the only clock (rising edge)
//   rst_n             - synchronous active-low reset
//   tdi / tdo         - serial data from / to the host (tdo = shreg[0])
//   test_logic_reset  - TAP in Test-Logic-Reset, synchronous soft clear
//   run_test_idle     - TAP in Run-Test/Idle, informational only
//   ir_is_user        - IR holds USER4; gates capture/shift/update
//   capture_dr, shift_dr, update_dr - TAP DR state flags
//   result            - solver answer, sampled at capture
//   result_valid      - result is final; otherwise zeros are captured
//   inbound_byte      - last received byte
//   inbound_valid     - one-cycle strobe qualifying inbound_byte
//   frame_error       - sticky, a scan had neither 8 nor >= RESULT_WIDTH bits

module jtag_user_dr_endpoint #(
  parameter int RESULT_WIDTH = 32
) (
  input  logic                    tck,
  input  logic                    rst_n,
  input  logic                    tdi,
  output logic                    tdo,
  input  logic                    test_logic_reset,
  input  logic                    run_test_idle,
  input  logic                    ir_is_user,
  input  logic                    capture_dr,
  input  logic                    shift_dr,
  input  logic                    update_dr,
  input  logic [RESULT_WIDTH-1:0] result,
  input  logic                    result_valid,
  output logic [7:0]              inbound_byte,
  output logic                    inbound_valid,
  output logic                    frame_error
);

  localparam int CW = $clog2(RESULT_WIDTH) + 1;
  localparam logic [CW-1:0] BYTE_BITS = CW'(8);
  localparam logic [CW-1:0] FULL_BITS = CW'(RESULT_WIDTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURED = 2'd1,
    SHIFTING = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [RESULT_WIDTH-1:0] shreg;
  logic [CW-1:0]           bitcnt;
  logic                    byte_pending;
  logic                    do_capture;
  logic                    do_shift;
  logic                    do_update;

  // Run-Test/Idle carries no meaning for this channel.
  logic unused_inputs;
  assign unused_inputs = run_test_idle;

  assign tdo = shreg[0];

  // State register.
  always_ff @(posedge tck) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and action decode. Priority resolves illegal simultaneous
  // flags: test_logic_reset > capture > shift > update. Shift and update
  // only act after a capture, so stray flags while IDLE are no-ops.
  always_comb begin
    state_next = state;
    do_capture = 1'b0;
    do_shift   = 1'b0;
    do_update  = 1'b0;
    if (test_logic_reset) begin
      state_next = IDLE;
    end else if (ir_is_user) begin
      if (capture_dr) begin
        state_next = CAPTURED;
        do_capture = 1'b1;
      end else if (shift_dr) begin
        if (state != IDLE) begin
          state_next = SHIFTING;
          do_shift   = 1'b1;
        end
      end else if (update_dr) begin
        if (state != IDLE) begin
          state_next = IDLE;
          do_update  = 1'b1;
        end
      end
    end
  end

  // Datapath. The received byte is latched at the update edge while the
  // strobe is delayed one edge through byte_pending, so inbound_valid
  // rises on the edge after update_dr is sampled.
  always_ff @(posedge tck) begin
    if (!rst_n) begin
      shreg         <= '0;
      bitcnt        <= '0;
      inbound_byte  <= 8'h00;
      inbound_valid <= 1'b0;
      byte_pending  <= 1'b0;
      frame_error   <= 1'b0;
    end else if (test_logic_reset) begin
      bitcnt        <= '0;
      inbound_valid <= 1'b0;
      byte_pending  <= 1'b0;
    end else begin
      inbound_valid <= byte_pending;
      byte_pending  <= 1'b0;
      if (do_capture) begin
        shreg  <= result_valid ? result : '0;
        bitcnt <= '0;
      end else if (do_shift) begin
        shreg <= {tdi, shreg[RESULT_WIDTH-1:1]};
        if (bitcnt != FULL_BITS) begin
          bitcnt <= bitcnt + 1'b1;
        end
      end else if (do_update) begin
        // A write frame leaves its first-shifted bit at RESULT_WIDTH-8.
        if (bitcnt == BYTE_BITS) begin
          inbound_byte <= shreg[RESULT_WIDTH-1 -: 8];
          byte_pending <= 1'b1;
        end else if ((bitcnt != FULL_BITS) && (bitcnt != '0)) begin
          frame_error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtag_user_dr_endpoint.sv
// tb_jtag_user_dr_endpoint
//
// Directed host sequence for the USER4 DR endpoint. Host drives inputs on
// falling tck and samples tdo / outputs on falling tck. Written bytes are
// pushed to a scoreboard queue and popped by a monitor on each strobe.

module tb_jtag_user_dr_endpoint;

  localparam int RW = 32;

  logic          tck = 1'b0;
  logic          rst_n = 1'b0;
  logic          tdi = 1'b0;
  logic          tdo;
  logic          test_logic_reset = 1'b0;
  logic          run_test_idle = 1'b0;
  logic          ir_is_user = 1'b1;
  logic          capture_dr = 1'b0;
  logic          shift_dr = 1'b0;
  logic          update_dr = 1'b0;
  logic [RW-1:0] result = '0;
  logic          result_valid = 1'b0;
  logic [7:0]    inbound_byte;
  logic          inbound_valid;
  logic          frame_error;

  int            checks = 0;
  int            errors = 0;
  int            strobe_count = 0;
  int            pushed_count = 0;
  logic [7:0]    sb_queue[$];
  logic          tdo_seen;
  logic [31:0]   word;

  jtag_user_dr_endpoint #(.RESULT_WIDTH(RW)) dut (
    .tck              (tck),
    .rst_n            (rst_n),
    .tdi              (tdi),
    .tdo              (tdo),
    .test_logic_reset (test_logic_reset),
    .run_test_idle    (run_test_idle),
    .ir_is_user       (ir_is_user),
    .capture_dr       (capture_dr),
    .shift_dr         (shift_dr),
    .update_dr        (update_dr),
    .result           (result),
    .result_valid     (result_valid),
    .inbound_byte     (inbound_byte),
    .inbound_valid    (inbound_valid),
    .frame_error      (frame_error)
  );

  always #5 tck = ~tck;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One TAP cycle: sample tdo at the falling edge, then drive the flags.
  task automatic applyStimulus(input logic cap, input logic shf, input logic upd, input logic din);
    @(negedge tck);
    tdo_seen   = tdo;
    capture_dr = cap;
    shift_dr   = shf;
    update_dr  = upd;
    tdi        = din;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Scan of nbits bits of data, optionally pushed as an expected byte.
  task automatic scanBits(input logic [7:0] data, input int nbits, input logic expect_byte);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) applyStimulus(1'b0, 1'b1, 1'b0, data[i % 8]);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    if (expect_byte) begin
      sb_queue.push_back(data);
      pushed_count++;
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    idleCycles(1);
  endtask

  task automatic readback(output logic [31:0] w);
    w = '0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < RW; j++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      w[j] = tdo_seen;
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    idleCycles(2);
  endtask

  // Scoreboard monitor: every strobe must match the oldest pushed byte.
  always @(negedge tck) begin
    if (inbound_valid === 1'b1) begin
      strobe_count++;
      checks++;
      assert (sb_queue.size() != 0) else begin
        errors++;
        $error("[TB] FAIL unexpected_strobe observed byte=%h expected no strobe", inbound_byte);
      end
      if (sb_queue.size() != 0) checkOutput("strobe_byte", {24'h0, inbound_byte}, {24'h0, sb_queue.pop_front()});
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Reset.
    rst_n = 1'b0;
    idleCycles(2);
    checkOutput("reset_tdo", {31'h0, tdo}, 32'h0);
    checkOutput("reset_byte", {24'h0, inbound_byte}, 32'h0);
    checkOutput("reset_valid", {31'h0, inbound_valid}, 32'h0);
    checkOutput("reset_ferr", {31'h0, frame_error}, 32'h0);
    rst_n = 1'b1;
    idleCycles(2);

    // Directed write of 0x41 with strobe timing checks.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h41 >> i);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    sb_queue.push_back(8'h41);
    pushed_count++;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("valid_not_early", {31'h0, inbound_valid}, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("valid_one_edge_after", {31'h0, inbound_valid}, 32'h1);
    checkOutput("byte_0x41", {24'h0, inbound_byte}, 32'h41);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("valid_one_cycle", {31'h0, inbound_valid}, 32'h0);

    // Readback when not ready, then ready.
    result       = 32'h0000_0A2B;
    result_valid = 1'b0;
    readback(word);
    checkOutput("readback_not_ready", word, 32'h0);
    result_valid = 1'b1;
    readback(word);
    checkOutput("readback_ready", word, 32'h0000_0A2B);
    result = 32'hDEAD_BEEF;
    readback(word);
    checkOutput("readback_other", word, 32'hDEAD_BEEF);
    checkOutput("readback_no_ferr", {31'h0, frame_error}, 32'h0);

    // Gated frame: a 5-bit scan with ir_is_user low changes nothing.
    ir_is_user = 1'b0;
    scanBits(8'h1F, 5, 1'b0);
    scanBits(8'h77, 8, 1'b0);
    idleCycles(2);
    ir_is_user = 1'b1;
    checkOutput("gated_ferr", {31'h0, frame_error}, 32'h0);
    checkOutput("gated_byte", {24'h0, inbound_byte}, 32'h41);

    // Test-Logic-Reset mid-scan returns to IDLE, later update is a no-op.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    test_logic_reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    test_logic_reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    idleCycles(1);
    checkOutput("tlr_no_ferr", {31'h0, frame_error}, 32'h0);

    // Malformed 5-bit frame sets the sticky error.
    scanBits(8'h15, 5, 1'b0);
    checkOutput("short_ferr", {31'h0, frame_error}, 32'h1);
    idleCycles(3);
    checkOutput("short_ferr_sticky", {31'h0, frame_error}, 32'h1);

    // Abort by reset after 4 shifts.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("abort_tdo", {31'h0, tdo}, 32'h0);
    checkOutput("abort_byte", {24'h0, inbound_byte}, 32'h0);
    checkOutput("abort_valid", {31'h0, inbound_valid}, 32'h0);
    checkOutput("abort_ferr", {31'h0, frame_error}, 32'h0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    idleCycles(1);
    scanBits(8'h0A, 8, 1'b1);
    idleCycles(2);
    checkOutput("after_abort_byte", {24'h0, inbound_byte}, 32'h0A);

    // Stream of 100 back-to-back random bytes.
    for (int n = 0; n < 100; n++) begin
      scanBits(8'($urandom_range(0, 255)), 8, 1'b1);
      idleCycles(2);
    end
    idleCycles(4);
    checkOutput("stream_queue_drained", sb_queue.size(), 32'h0);
    checkOutput("stream_strobe_count", strobe_count, pushed_count);
    checkOutput("stream_no_ferr", {31'h0, frame_error}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
